// File: rtl/sect_pkg.sv
// Shared FSM encoding and per-curve constants for the SEC 2 binary-curve point blocks.
package sect_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_M1   = 3'd1,
        ST_M2   = 3'd2,
        ST_M3   = 3'd3,
        ST_CMP  = 3'd4
    } sect_state_e;

    localparam int unsigned SECT571R1_M = 571;
    localparam logic [SECT571R1_M-1:0] SECT571R1_FX = 571'h425;
    localparam int unsigned SECT571R1_A = 1;
    localparam logic [SECT571R1_M-1:0] SECT571R1_B =
        571'h2f40e7e_2221f295_de297117_b7f3d62f_5c6a97ff_cb8ceff1_cd6ba8ce_4a9a18ad_84ffabbd_8efa5933_2be7ad67_56a66e29_4afd185a_78ff12aa_520e4de7_39baca0c_7ffeff7f_2955727a;
    localparam int unsigned SECT571R1_NUM_CYCLE_MUL = 9;

endpackage

// File: rtl/f2m_mul.sv
// Digit-serial GF(2^M) multiplier: NUM_CYCLE_MUL+1 MSB-first digit steps, done pulses
// NUM_CYCLE_MUL+1 cycles after start_i, product held on p_o until the next start.
module f2m_mul #(
    parameter int unsigned  M             = 571,
    parameter logic [M-1:0] FX            = M'(11'h425),
    parameter int unsigned  NUM_CYCLE_MUL = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [M-1:0] a_i,
    input  logic [M-1:0] b_i,
    output logic         done_o,
    output logic [M-1:0] p_o
);

    localparam int unsigned NUM_DIG = NUM_CYCLE_MUL + 1;
    localparam int unsigned DIG_W   = (M + NUM_DIG - 1) / NUM_DIG;
    localparam int unsigned PAD_W   = DIG_W * NUM_DIG;
    localparam int unsigned CNT_W   = $clog2(NUM_DIG + 1);

    logic [M-1:0]     a_q, a_d;
    logic [M-1:0]     acc_q, acc_d;
    logic [PAD_W-1:0] b_q, b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [M-1:0]     step_a_c;
    logic [PAD_W-1:0] step_b_c;
    logic [M-1:0]     acc_step_c;

    // The first digit is folded into the start cycle so the whole product takes NUM_DIG edges.
    always_comb begin
        step_a_c   = start_i ? a_i : a_q;
        step_b_c   = start_i ? PAD_W'(b_i) : b_q;
        acc_step_c = start_i ? '0 : acc_q;
        for (int unsigned i = 0; i < DIG_W; i++) begin
            acc_step_c = {acc_step_c[M-2:0], 1'b0} ^ (acc_step_c[M-1] ? FX : '0);
            if (step_b_c[PAD_W-1-i]) begin
                acc_step_c = acc_step_c ^ step_a_c;
            end
        end
    end

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (start_i) begin
            a_d   = a_i;
            b_d   = step_b_c << DIG_W;
            acc_d = acc_step_c;
            cnt_d = CNT_W'(1);
            if (NUM_DIG == 1) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                busy_d = 1'b1;
            end
        end else if (busy_q) begin
            b_d   = b_q << DIG_W;
            acc_d = acc_step_c;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(NUM_DIG - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign done_o = done_q;
    assign p_o    = acc_q;

endmodule

// File: rtl/sect_pt_check.sv
// Point-on-curve check y^2 + x*y = x^3 + A*x^2 + B over GF(2^M) with one shared multiplier.
// Optional SECT_PT_CHECK_INF_EN: (0,0) is taken as the point at infinity and flagged on inf.
module sect_pt_check
    import sect_pkg::*;
#(
    parameter int unsigned  M             = SECT571R1_M,
    parameter logic [M-1:0] FX            = M'(SECT571R1_FX),
    parameter int unsigned  A             = SECT571R1_A,
    parameter logic [M-1:0] B             = M'(SECT571R1_B),
    parameter int unsigned  NUM_CYCLE_MUL = SECT571R1_NUM_CYCLE_MUL
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         start,
    input  logic [M-1:0] x,
    input  logic [M-1:0] y,
    output logic         done,
    output logic         valid
`ifdef SECT_PT_CHECK_INF_EN
    ,
    output logic         inf
`endif
);

    sect_state_e  state_q, state_d;
    logic [M-1:0] x_q, x_d;
    logic [M-1:0] y_q, y_d;
    logic [M-1:0] t1_q, t1_d;
    logic [M-1:0] t2_q, t2_d;
    logic [M-1:0] t3_q, t3_d;
    logic         mul_start_q, mul_start_d;
    logic         done_q, done_d;
    logic         valid_q, valid_d;
`ifdef SECT_PT_CHECK_INF_EN
    logic         inf_q, inf_d;
`endif

    logic [M-1:0] mul_a_c, mul_b_c;
    logic [M-1:0] mul_p;
    logic         mul_done;
    logic         mul_rst;

    // Clearing the multiplier too guarantees an aborted product never leaks into a later run.
    assign mul_rst = rst | clr;

    f2m_mul #(
        .M             (M),
        .FX            (FX),
        .NUM_CYCLE_MUL (NUM_CYCLE_MUL)
    ) u_mul (
        .clk     (clk),
        .rst     (mul_rst),
        .start_i (mul_start_q),
        .a_i     (mul_a_c),
        .b_i     (mul_b_c),
        .done_o  (mul_done),
        .p_o     (mul_p)
    );

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        t1_d        = t1_q;
        t2_d        = t2_q;
        t3_d        = t3_q;
        mul_start_d = 1'b0;
        done_d      = 1'b0;
        valid_d     = valid_q;
`ifdef SECT_PT_CHECK_INF_EN
        inf_d       = inf_q;
`endif
        mul_a_c     = y_q;
        mul_b_c     = y_q ^ x_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    x_d     = x;
                    y_d     = y;
                    valid_d = 1'b0;
`ifdef SECT_PT_CHECK_INF_EN
                    inf_d   = 1'b0;
                    if ((x == '0) && (y == '0)) begin
                        state_d = ST_CMP;
                    end else begin
                        state_d     = ST_M1;
                        mul_start_d = 1'b1;
                    end
`else
                    state_d     = ST_M1;
                    mul_start_d = 1'b1;
`endif
                end
            end
            ST_M1: begin
                mul_a_c = y_q;
                mul_b_c = y_q ^ x_q;
                if (mul_done) begin
                    t1_d        = mul_p;
                    state_d     = ST_M2;
                    mul_start_d = 1'b1;
                end
            end
            ST_M2: begin
                mul_a_c = x_q;
                mul_b_c = x_q;
                if (mul_done) begin
                    t2_d        = mul_p;
                    state_d     = ST_M3;
                    mul_start_d = 1'b1;
                end
            end
            ST_M3: begin
                mul_a_c = t2_q;
                mul_b_c = x_q ^ M'(A);
                if (mul_done) begin
                    t3_d    = mul_p;
                    state_d = ST_CMP;
                end
            end
            ST_CMP: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
`ifdef SECT_PT_CHECK_INF_EN
                if ((x_q == '0) && (y_q == '0)) begin
                    valid_d = 1'b1;
                    inf_d   = 1'b1;
                end else begin
                    valid_d = (t1_q == (t3_q ^ B));
                end
`else
                valid_d = (t1_q == (t3_q ^ B));
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            t1_q        <= '0;
            t2_q        <= '0;
            t3_q        <= '0;
            mul_start_q <= 1'b0;
            done_q      <= 1'b0;
            valid_q     <= 1'b0;
`ifdef SECT_PT_CHECK_INF_EN
            inf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            t1_q        <= t1_d;
            t2_q        <= t2_d;
            t3_q        <= t3_d;
            mul_start_q <= mul_start_d;
            done_q      <= done_d;
            valid_q     <= valid_d;
`ifdef SECT_PT_CHECK_INF_EN
            inf_q       <= inf_d;
`endif
        end
    end

    assign done  = done_q;
    assign valid = valid_q;
`ifdef SECT_PT_CHECK_INF_EN
    assign inf   = inf_q;
`endif

endmodule
